physics_step_scheduler: RTL and testbench

Sequences one physics frame of the car simulation across the shared datapath. A single wheel updater is time-shared between the left and right wheels, then the body updater runs, then the centre-of-mass tabulation. This repeats for NUM_SUBSTEPS substeps per frame tick. The block sits between the frame-rate tick source and the car-update datapath, and drives the wheel-select mux, the begin strobes and the COM tabulate strobe.

---
 rtl/physics_step_scheduler.sv | 168 ++++++++++++++++
 tb/tb_physics_step_scheduler.sv | 233 +++++++++++++++++++++++
 2 files changed

// File: rtl/physics_step_scheduler.sv
// Physics frame sequencer: time-shares one wheel updater between the left and
// right wheels, then runs the body updater and the centre-of-mass tabulation,
// repeating for NUM_SUBSTEPS substeps per accepted frame tick. Every WAIT state
// is guarded by a watchdog, and ticks that arrive while busy are counted.
module physics_step_scheduler #(
  parameter int NUM_SUBSTEPS   = 4,
  parameter int TIMEOUT_CYCLES = 65535,
  parameter int OVERRUN_WIDTH  = 8
) (
  input  logic                            clk_in,
  input  logic                            rst_in,
  input  logic                            step_tick_in,
  input  logic                            enable_in,
  input  logic                            wheel_done_in,
  input  logic                            body_done_in,
  input  logic                            com_valid_in,
  output logic                            wheel_begin_out,
  output logic                            wheel_sel_out,
  output logic                            body_begin_out,
  output logic                            com_tabulate_out,
  output logic                            busy_out,
  output logic                            step_done_out,
  output logic [$clog2(NUM_SUBSTEPS):0]   substep_out,
  output logic                            timeout_err_out,
  output logic [OVERRUN_WIDTH-1:0]        overrun_count_out
);

  localparam int SW = $clog2(NUM_SUBSTEPS) + 1;
  localparam int CW = $clog2(TIMEOUT_CYCLES) + 1;
  localparam logic [SW-1:0] SubLast  = SW'(NUM_SUBSTEPS - 1);
  localparam logic [CW-1:0] WdogLast = CW'(TIMEOUT_CYCLES - 2);

  typedef enum logic [3:0] {
    IDLE, LAUNCH_L, WAIT_L, LAUNCH_R, WAIT_R,
    LAUNCH_B, WAIT_B, LAUNCH_C, WAIT_C, DONE
  } state_t;

  state_t                   state_q, state_d;
  logic [SW-1:0]            substep_q, substep_d;
  logic [CW-1:0]            wdog_q, wdog_d;
  logic                     timeout_q, timeout_d;
  logic [OVERRUN_WIDTH-1:0] overrun_q, overrun_d;
  logic                     sel_q, sel_d;
  logic                     wheelBegin_q, wheelBegin_d;
  logic                     bodyBegin_q, bodyBegin_d;
  logic                     comTab_q, comTab_d;
  logic                     busy_q, busy_d;
  logic                     stepDone_q, stepDone_d;
  logic                     inWait;
  logic                     expired;

  // Next-state, watchdog, overrun and registered-output decode
  always_comb begin
    state_d     = state_q;
    substep_d   = substep_q;
    timeout_d   = timeout_q;
    overrun_d   = overrun_q;
    inWait      = (state_q == WAIT_L) || (state_q == WAIT_R) ||
                  (state_q == WAIT_B) || (state_q == WAIT_C);
    expired     = (wdog_q == WdogLast);

    case (state_q)
      IDLE: begin
        if (step_tick_in && enable_in) begin
          state_d   = LAUNCH_L;
          substep_d = '0;
          timeout_d = 1'b0;
        end
      end
      LAUNCH_L: state_d = WAIT_L;
      WAIT_L: begin
        if (wheel_done_in) state_d = LAUNCH_R;
        else if (expired) begin
          state_d   = IDLE;
          timeout_d = 1'b1;
        end
      end
      LAUNCH_R: state_d = WAIT_R;
      WAIT_R: begin
        if (wheel_done_in) state_d = LAUNCH_B;
        else if (expired) begin
          state_d   = IDLE;
          timeout_d = 1'b1;
        end
      end
      LAUNCH_B: state_d = WAIT_B;
      WAIT_B: begin
        if (body_done_in) state_d = LAUNCH_C;
        else if (expired) begin
          state_d   = IDLE;
          timeout_d = 1'b1;
        end
      end
      LAUNCH_C: state_d = WAIT_C;
      WAIT_C: begin
        if (com_valid_in) begin
          if (substep_q == SubLast) state_d = DONE;
          else begin
            state_d   = LAUNCH_L;
            substep_d = substep_q + 1'b1;
          end
        end else if (expired) begin
          state_d   = IDLE;
          timeout_d = 1'b1;
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase

    // The watchdog restarts from zero on every WAIT entry and counts while it stays
    wdog_d = (inWait && (state_d == state_q)) ? wdog_q + 1'b1 : '0;

    if ((state_q != IDLE) && step_tick_in && (overrun_q != '1))
      overrun_d = overrun_q + 1'b1;

    // The mux select moves only when a wheel launch begins, and parks at left when idle
    if (state_d == LAUNCH_R)                           sel_d = 1'b1;
    else if ((state_d == LAUNCH_L) || (state_d == IDLE)) sel_d = 1'b0;
    else                                               sel_d = sel_q;

    wheelBegin_d = (state_d == LAUNCH_L) || (state_d == LAUNCH_R);
    bodyBegin_d  = (state_d == LAUNCH_B);
    comTab_d     = (state_d == LAUNCH_C);
    busy_d       = (state_d != IDLE);
    stepDone_d   = (state_d == DONE);
  end

  // State and output registers; reset clears everything immediately
  always_ff @(posedge clk_in or negedge rst_in) begin
    if (!rst_in) begin
      state_q      <= IDLE;
      substep_q    <= '0;
      wdog_q       <= '0;
      timeout_q    <= 1'b0;
      overrun_q    <= '0;
      sel_q        <= 1'b0;
      wheelBegin_q <= 1'b0;
      bodyBegin_q  <= 1'b0;
      comTab_q     <= 1'b0;
      busy_q       <= 1'b0;
      stepDone_q   <= 1'b0;
    end else begin
      state_q      <= state_d;
      substep_q    <= substep_d;
      wdog_q       <= wdog_d;
      timeout_q    <= timeout_d;
      overrun_q    <= overrun_d;
      sel_q        <= sel_d;
      wheelBegin_q <= wheelBegin_d;
      bodyBegin_q  <= bodyBegin_d;
      comTab_q     <= comTab_d;
      busy_q       <= busy_d;
      stepDone_q   <= stepDone_d;
    end
  end

  assign wheel_begin_out   = wheelBegin_q;
  assign wheel_sel_out     = sel_q;
  assign body_begin_out    = bodyBegin_q;
  assign com_tabulate_out  = comTab_q;
  assign busy_out          = busy_q;
  assign step_done_out     = stepDone_q;
  assign substep_out       = substep_q;
  assign timeout_err_out   = timeout_q;
  assign overrun_count_out = overrun_q;

endmodule

// File: tb/tb_physics_step_scheduler.sv
// Bench for physics_step_scheduler: a responder returns done pulses after
// programmable delays, a scoreboard holds the expected strobe timeline of each
// frame, and a negedge monitor pops and compares every strobe it sees.
module tb_physics_step_scheduler;

  localparam int NSUB = 2;
  localparam int TMO  = 32;
  localparam int OW   = 8;

  logic clk_in = 1'b0;
  always #5 clk_in = ~clk_in;

  logic          rst_in, step_tick_in, enable_in;
  logic          respWheel, respBody, respCom, spurWheel, spurBody;
  logic          wheel_done_in, body_done_in, com_valid_in;
  logic          wheel_begin_out, wheel_sel_out, body_begin_out, com_tabulate_out;
  logic          busy_out, step_done_out, timeout_err_out;
  logic [1:0]    substep_out;
  logic [OW-1:0] overrun_count_out;

  assign wheel_done_in = respWheel | spurWheel;
  assign body_done_in  = respBody | spurBody;
  assign com_valid_in  = respCom;

  physics_step_scheduler #(
    .NUM_SUBSTEPS(NSUB), .TIMEOUT_CYCLES(TMO), .OVERRUN_WIDTH(OW)
  ) dut (
    .clk_in(clk_in), .rst_in(rst_in), .step_tick_in(step_tick_in),
    .enable_in(enable_in), .wheel_done_in(wheel_done_in),
    .body_done_in(body_done_in), .com_valid_in(com_valid_in),
    .wheel_begin_out(wheel_begin_out), .wheel_sel_out(wheel_sel_out),
    .body_begin_out(body_begin_out), .com_tabulate_out(com_tabulate_out),
    .busy_out(busy_out), .step_done_out(step_done_out),
    .substep_out(substep_out), .timeout_err_out(timeout_err_out),
    .overrun_count_out(overrun_count_out)
  );

  // kind: 0 wheel begin, 1 body begin, 2 com tabulate, 3 step done
  typedef struct { int kind; int cyc; int sel; int sub; } evt_t;
  evt_t expQ[$];

  int errors = 0, checks = 0;
  int edgeNum = 0, frameStart = 0, selModel = 0, monCyc;
  int dL = 1, dR = 1, dB = 1, dC = 1;
  int wCnt = -1, bCnt = -1, cCnt = -1;
  int issued = 0, endCyc, ovSaved;

  task automatic checkOutput(input string tag, input int actual, input int expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got %0d expected %0d", tag, actual, expected);
    end
  endtask

  // Expected strobe timeline; a delay of 0 on the body means it never answers
  task automatic pushFrame(input int l, input int r, input int b, input int c);
    int t;
    t = 1;
    for (int s = 0; s < NSUB; s++) begin
      expQ.push_back('{0, t, 0, s}); t += l + 1;
      expQ.push_back('{0, t, 1, s}); t += r + 1;
      expQ.push_back('{1, t, 0, s});
      if (b == 0) return;
      t += b + 1;
      expQ.push_back('{2, t, 0, s}); t += c + 1;
    end
    expQ.push_back('{3, t, 0, NSUB - 1});
  endtask

  task automatic popCheck(input int kind, input int cyc);
    evt_t e;
    if (expQ.size() == 0) begin
      checkOutput("unexpected_strobe", kind, -1);
      return;
    end
    e = expQ.pop_front();
    checkOutput("strobe_kind", kind, e.kind);
    checkOutput("strobe_cycle", cyc, e.cyc);
    checkOutput("strobe_substep", int'(substep_out), e.sub);
    if (kind == 0) begin
      checkOutput("launch_sel", int'(wheel_sel_out), e.sel);
      selModel = e.sel;
    end
  endtask

  always @(posedge clk_in) edgeNum <= edgeNum + 1;

  // Monitor: every strobe must match the scoreboard, and the mux select must hold
  always @(negedge clk_in) begin
    monCyc = edgeNum - frameStart + 1;
    if (wheel_begin_out)  popCheck(0, monCyc);
    if (body_begin_out)   popCheck(1, monCyc);
    if (com_tabulate_out) popCheck(2, monCyc);
    if (step_done_out)    popCheck(3, monCyc);
    if (!busy_out) checkOutput("sel_idle", int'(wheel_sel_out), 0);
    else           checkOutput("sel_hold", int'(wheel_sel_out), selModel);
  end

  // Responder: each strobe schedules its done pulse a programmed number of cycles later
  always @(negedge clk_in) begin
    respWheel = 1'b0; respBody = 1'b0; respCom = 1'b0;
    if (!rst_in) begin
      wCnt = -1; bCnt = -1; cCnt = -1;
    end else begin
      if (wCnt > 0) begin wCnt--; if (wCnt == 0) begin respWheel = 1'b1; wCnt = -1; end end
      if (bCnt > 0) begin bCnt--; if (bCnt == 0) begin respBody  = 1'b1; bCnt = -1; end end
      if (cCnt > 0) begin cCnt--; if (cCnt == 0) begin respCom   = 1'b1; cCnt = -1; end end
      if (wheel_begin_out)  wCnt = wheel_sel_out ? dR : dL;
      if (body_begin_out)   bCnt = (dB == 0) ? -1 : dB;
      if (com_tabulate_out) cCnt = dC;
    end
  end

  task automatic applyStimulus(input int l, input int r, input int b, input int c);
    dL = l; dR = r; dB = b; dC = c;
    pushFrame(l, r, b, c);
    @(negedge clk_in);
    frameStart   = edgeNum + 1;
    step_tick_in = 1'b1;
  endtask

  // mode 0 quiet, 1 three busy ticks, 2 tick every busy cycle, 3 spurious dones
  task automatic runFrame(input int mode, output int lastCyc);
    int c;
    bit gotIdle;
    gotIdle = 1'b0;
    lastCyc = -1;
    for (int i = 0; i < 400; i++) begin
      @(negedge clk_in);
      c = edgeNum - frameStart + 1;
      step_tick_in = 1'b0; spurWheel = 1'b0; spurBody = 1'b0;
      if (c == 1) begin
        checkOutput("busy_start", int'(busy_out), 1);
        checkOutput("timeout_clear", int'(timeout_err_out), 0);
      end
      if (!busy_out) begin
        lastCyc = c; gotIdle = 1'b1;
        break;
      end
      case (mode)
        1: step_tick_in = (c == 3) || (c == 5) || (c == 7);
        2: if (issued < 300) begin step_tick_in = 1'b1; issued++; end
        3: begin spurBody = (c == 2); spurWheel = (c == 6); end
        default: ;
      endcase
    end
    if (!gotIdle) checkOutput("frame_end_bound", 0, 1);
    checkOutput("events_left", expQ.size(), 0);
    expQ.delete();
  endtask

  initial begin
    rst_in = 1'b0; step_tick_in = 1'b0; enable_in = 1'b1;
    spurWheel = 1'b0; spurBody = 1'b0;
    repeat (3) @(negedge clk_in);
    checkOutput("rst_busy", int'(busy_out), 0);
    checkOutput("rst_begin", int'(wheel_begin_out), 0);
    checkOutput("rst_substep", int'(substep_out), 0);
    checkOutput("rst_overrun", int'(overrun_count_out), 0);
    rst_in = 1'b1;
    repeat (2) @(negedge clk_in);

    // Baseline frame, every done one cycle after its strobe
    applyStimulus(1, 1, 1, 1);
    runFrame(0, endCyc);
    checkOutput("base_end_cycle", endCyc, 18);
    checkOutput("base_substep_final", int'(substep_out), 1);

    // Slow right wheel: 21 WAIT_R cycles, select held high throughout
    applyStimulus(1, 21, 1, 1);
    runFrame(0, endCyc);

    // Disabled tick and spurious wheel done in IDLE start nothing
    ovSaved = int'(overrun_count_out);
    enable_in = 1'b0;
    @(negedge clk_in); step_tick_in = 1'b1; spurWheel = 1'b1;
    @(negedge clk_in); step_tick_in = 1'b0; spurWheel = 1'b0;
    repeat (2) @(negedge clk_in);
    checkOutput("disabled_busy", int'(busy_out), 0);
    checkOutput("disabled_overrun", int'(overrun_count_out), ovSaved);
    enable_in = 1'b1;

    // Spurious body done in WAIT_L and wheel done in LAUNCH_R are ignored
    applyStimulus(4, 3, 1, 1);
    runFrame(3, endCyc);

    // Body never answers: abort after TMO-1 WAIT_B cycles
    applyStimulus(1, 1, 0, 1);
    runFrame(0, endCyc);
    checkOutput("timeout_end_cycle", endCyc, 5 + TMO);
    checkOutput("timeout_flag", int'(timeout_err_out), 1);

    // Done in the final watchdog cycle wins; the new tick clears the flag
    applyStimulus(1, 1, TMO - 1, 1);
    runFrame(0, endCyc);
    checkOutput("lastcycle_no_timeout", int'(timeout_err_out), 0);

    // Overrun counting and saturation
    applyStimulus(1, 1, 1, 1);
    runFrame(1, endCyc);
    checkOutput("overrun_three", int'(overrun_count_out), 3);
    applyStimulus(30, 30, 30, 30);
    runFrame(2, endCyc);
    checkOutput("overrun_252", int'(overrun_count_out), 252);
    applyStimulus(30, 30, 30, 30);
    runFrame(2, endCyc);
    checkOutput("overrun_saturated", int'(overrun_count_out), 255);

    // Asynchronous reset in WAIT_R, then a fresh frame
    applyStimulus(1, 10, 1, 1);
    @(negedge clk_in); step_tick_in = 1'b0;
    repeat (5) @(negedge clk_in);
    checkOutput("pre_reset_sel", int'(wheel_sel_out), 1);
    rst_in = 1'b0;
    #1;
    checkOutput("async_busy", int'(busy_out), 0);
    checkOutput("async_sel", int'(wheel_sel_out), 0);
    checkOutput("async_substep", int'(substep_out), 0);
    checkOutput("async_overrun", int'(overrun_count_out), 0);
    checkOutput("async_done", int'(step_done_out), 0);
    expQ.delete();
    repeat (2) @(negedge clk_in);
    rst_in = 1'b1;
    applyStimulus(1, 1, 1, 1);
    runFrame(0, endCyc);
    checkOutput("post_reset_end_cycle", endCyc, 18);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
